sync_ram_ctrl: RTL and testbench

//  Upstream request controller for the single-port sync_ram (we/addr/din/dout, 1-cycle registered read).

---
 rtl/sync_ram_ctrl_pkg.sv | 12 +
 rtl/ram_rsp_fifo.sv | 67 ++++++
 rtl/sync_ram_ctrl.sv | 115 +++++++++++
 tb/tb_sync_ram_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_ram_ctrl_pkg.sv
// Shared types and default widths for the sync_ram request controller.
package sync_ram_ctrl_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } ctrl_state_e;

   localparam int unsigned DEF_ADDR_WIDTH = 4;
   localparam int unsigned DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/ram_rsp_fifo.sv
// Synchronous response FIFO holding read data until the consumer takes it.
// Head word is presented combinationally; a zero word is shown while empty.
module ram_rsp_fifo #(
   parameter  int unsigned DW    = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // NOTE: every next-state variable gets its default first so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; emptiness is tracked by count_q, which is.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/sync_ram_ctrl.sv
// Request/response controller for a single-port sync_ram with 1-cycle read latency.
// Optional RAM_CTRL_INIT_EN: after reset, sweep every word to INIT_VALUE before accepting requests.
module sync_ram_ctrl
   import sync_ram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned RSP_DEPTH  = 4
`ifdef RAM_CTRL_INIT_EN
   ,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic                  init_done
);

   localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

   logic          run;
   logic          fire;
   logic          rd_pend_q, rd_pend_d;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   credit_used;

   // A read in flight already owns a FIFO slot, so it counts against the credit.
   assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend_q};
   assign req_ready   = run & ~fifo_full & (credit_used < (CW+1)'(RSP_DEPTH));
   assign fire        = req_valid & req_ready;
   assign rd_pend_d   = fire & ~req_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_pend_q <= 1'b0;
      else        rd_pend_q <= rd_pend_d;
   end

`ifdef RAM_CTRL_INIT_EN
   ctrl_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         init_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      ram_we      = fire & req_we;
      ram_addr    = req_addr;
      ram_din     = req_wdata;
      if (state_q == ST_INIT) begin
         ram_we      = 1'b1;
         ram_addr    = init_addr_q;
         ram_din     = INIT_VALUE;
         init_addr_d = init_addr_q + 1'b1;
         if (init_addr_q == {ADDR_WIDTH{1'b1}}) state_d = ST_RUN;
      end
   end

   assign run       = (state_q == ST_RUN);
   assign init_done = run;
`else
   logic run_q;

   // Keeps req_ready low while reset is held; RUN is entered on the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

   assign run       = run_q;
   assign init_done = 1'b1;
   assign ram_we    = fire & req_we;
   assign ram_addr  = req_addr;
   assign ram_din   = req_wdata;
`endif

   ram_rsp_fifo #(
      .DW    (DATA_WIDTH),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (rd_pend_q),
      .wdata_i (ram_dout),
      .pop_i   (rsp_ready),
      .rdata_o (rsp_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign rsp_valid = ~fifo_empty;

endmodule

// File: tb/tb_sync_ram_ctrl.sv
// Directed bench for sync_ram_ctrl driving a behavioural single-port sync RAM.
// Init-sweep checks are compiled in when RAM_CTRL_INIT_EN is defined.
module tb_sync_ram_ctrl;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din, ram_dout;
   logic          init_done;

   int tests = 0;
   int fails = 0;

`ifdef RAM_CTRL_INIT_EN
   localparam logic EXP_INIT_DONE_RST = 1'b0;
   localparam logic [DW-1:0] EXP_AFTER_RESET_5 = 8'h00;
`else
   localparam logic EXP_INIT_DONE_RST = 1'b1;
   localparam logic [DW-1:0] EXP_AFTER_RESET_5 = 8'h3C;
`endif

   always #5 clk = ~clk;

   // Behavioural sync_ram: registered read, read-before-write on the same edge.
   logic [DW-1:0] mem [2**AW];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   sync_ram_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .init_done (init_done)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
   endtask

   task automatic wait_ready;
      int n = 0;
      while (req_ready !== 1'b1 && n < 64) begin
         tick;
         n++;
      end
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL wait_ready: req_ready=%b after %0d cycles, want 1", req_ready, n); end
   endtask

   task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wait_ready;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      tick;
      idle_inputs;
   endtask

   task automatic test_reset;
      rsp_ready = 1'b0;
      idle_inputs;
      rst_n = 1'b0;
      #3;
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      tests++; if (rsp_rdata !== 8'h00) begin fails++; $display("FAIL rst_rsp_rdata: got %h want 00", rsp_rdata); end
      tests++; if (ram_we !== 1'b0 && EXP_INIT_DONE_RST) begin fails++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
      tests++; if (init_done !== EXP_INIT_DONE_RST) begin fails++; $display("FAIL rst_init_done: got %b want %b", init_done, EXP_INIT_DONE_RST); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

`ifdef RAM_CTRL_INIT_EN
   task automatic test_init;
      idle_inputs;
      rsp_ready = 1'b1;
      rst_n = 1'b0;
      #7;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tests++; if (req_ready !== 1'b0 || init_done !== 1'b0) begin fails++; $display("FAIL init_busy[%0d]: ready=%b done=%b want 0 0", i, req_ready, init_done); end
         tick;
      end
      tests++; if (req_ready !== 1'b1 || init_done !== 1'b1) begin fails++; $display("FAIL init_end: ready=%b done=%b want 1 1", req_ready, init_done); end
      send(1'b0, 4'd15, 8'h00);
      tick;
      tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00) begin fails++; $display("FAIL init_rd15: valid=%b data=%h want 1 00", rsp_valid, rsp_rdata); end
      tick;
   endtask
`endif

   task automatic test_write_read;
      rsp_ready = 1'b1;
      send(1'b1, 4'd3, 8'hA5);
      wait_ready;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 4'd3;
      tick;
      idle_inputs;
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_rd_lat1: rsp_valid=%b want 0", rsp_valid); end
      tick;
      tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin fails++; $display("FAIL wr_rd_data: valid=%b data=%h want 1 a5", rsp_valid, rsp_rdata); end
      tick;
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wr_rd_single: rsp_valid=%b want 0", rsp_valid); end
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] exp;
      rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) send(1'b1, AW'(k), DW'(k * 17));
      for (int i = 0; i < 10; i++) begin
         if (i < 8) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = AW'(i);
            tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); end
         end else begin
            idle_inputs;
         end
         if (i >= 2) begin
            exp = DW'((i - 2) * 17);
            tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin fails++; $display("FAIL b2b_rsp[%0d]: valid=%b data=%h want 1 %h", i - 2, rsp_valid, rsp_rdata, exp); end
         end
         tick;
      end
      idle_inputs;
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_drained: rsp_valid=%b want 0", rsp_valid); end
   endtask

   task automatic test_backpressure;
      logic [AW-1:0] addr_seq [4];
      logic [DW-1:0] exp_seq [4];
      int accepted = 0;
      addr_seq = '{4'd7, 4'd6, 4'd5, 4'd4};
      exp_seq  = '{8'h77, 8'h66, 8'h55, 8'h44};
      rsp_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = (accepted < 4) ? addr_seq[accepted] : 4'd0;
         if (req_ready === 1'b1) accepted++;
         tick;
      end
      idle_inputs;
      tests++; if (accepted !== 4) begin fails++; $display("FAIL bp_accepted: got %0d want 4", accepted); end
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_full: got %b want 0", req_ready); end
      rsp_ready = 1'b1;
      #1;
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_pop_credit: got %b want 0", req_ready); end
      for (int j = 0; j < 4; j++) begin
         tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_seq[j]) begin fails++; $display("FAIL bp_rsp[%0d]: valid=%b data=%h want 1 %h", j, rsp_valid, rsp_rdata, exp_seq[j]); end
         tick;
      end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: rsp_valid=%b want 0", rsp_valid); end
   endtask

   task automatic test_write_then_read;
      rsp_ready = 1'b1;
      wait_ready;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 4'd5;
      req_wdata = 8'h3C;
      tick;
      req_we    = 1'b0;
      tick;
      idle_inputs;
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL wtr_lat1: rsp_valid=%b want 0", rsp_valid); end
      tick;
      tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h3C) begin fails++; $display("FAIL wtr_data: valid=%b data=%h want 1 3c", rsp_valid, rsp_rdata); end
      tick;
   endtask

   task automatic test_reset_midop;
      rsp_ready = 1'b0;
      send(1'b0, 4'd3, 8'h00);
      send(1'b0, 4'd6, 8'h00);
      tick;
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL mid_queued: rsp_valid=%b want 1", rsp_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_async_valid: rsp_valid=%b want 0", rsp_valid); end
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL mid_async_ready: req_ready=%b want 0", req_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      tick;
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_fifo_empty: rsp_valid=%b want 0", rsp_valid); end
      send(1'b0, 4'd5, 8'h00);
      tick;
      tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== EXP_AFTER_RESET_5) begin fails++; $display("FAIL mid_ram_kept: valid=%b data=%h want 1 %h", rsp_valid, rsp_rdata, EXP_AFTER_RESET_5); end
      tick;
   endtask

   initial begin
      idle_inputs;
      rsp_ready = 1'b0;
      test_reset;
`ifdef RAM_CTRL_INIT_EN
      test_init;
`endif
      test_write_read;
      test_back_to_back;
      test_backpressure;
      test_write_then_read;
      test_reset_midop;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
